// File: rtl/rv_alu_seq_pkg.sv
// Shared types and helpers for the sequential RV ALU and its M-extension iterator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_PASSB  = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Quotient returned for any divide by zero; slice to XLEN at the use site.
  localparam logic [63:0] DIV_BY_ZERO_Q = '1;

  // M-extension codes occupy 16..23.
  function automatic logic is_multicycle(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

  // DIV/DIVU/REM/REMU occupy 20..23.
  function automatic logic is_div_op(input logic [4:0] op);
    return (op[4:2] == 3'b101);
  endfunction

  // MULHSU treats A as signed and B as unsigned; MUL is sign-agnostic in its low half.
  function automatic logic op_a_signed(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv_alu_mdu_iter.sv
// Radix-2 iterator shared by unsigned shift-add multiply and restoring divide on magnitudes.
// Latency: XLEN steps after i_start; o_done flags the last step, o_hi/o_lo carry its result.
// Backpressure: none; i_kill abandons the operation, i_start reloads at any time.
module rv_alu_mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_kill,
  input  logic            i_start,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_ma,
  input  logic [XLEN-1:0] i_mb,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  localparam int CW = $clog2(XLEN + 1);

  // mul: r_hi:r_lo is the partial product, multiplier consumed from r_lo[0], r_m = multiplicand
  // div: r_hi is the partial remainder, dividend shifts out of r_lo as quotient shifts in, r_m = divisor
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;
  logic            r_div;
  logic [CW-1:0]   r_cnt;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  assign o_done = (r_cnt == CW'(1));
  assign o_hi   = w_hi_nxt;
  assign o_lo   = w_lo_nxt;

  // One radix-2 step: conditional add-and-shift-right, or shift-left-and-trial-subtract.
  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, r_m};
    w_trial  = {r_hi, r_lo[XLEN-1]};
    w_ge     = (w_trial >= {1'b0, r_m});
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_div) begin
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
      w_hi_nxt = w_ge ? (w_trial[XLEN-1:0] - r_m) : w_trial[XLEN-1:0];
    end else if (r_lo[0]) begin
      {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[XLEN-1:1]};
    end else begin
      {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[XLEN-1:1]};
    end
  end

  // Load operands on start, then step once per cycle while the counter is non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_m   <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (i_kill) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_hi  <= '0;
      r_div <= i_div;
      r_lo  <= i_div ? i_ma : i_mb;
      r_m   <= i_div ? i_mb : i_ma;
      r_cnt <= CW'(XLEN);
    end else if (r_cnt != '0) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rv_alu_seq.sv
// EX-stage RV ALU with registered result; M-extension iterator built only with RV_ALU_MDU_EN.
// Latency: 1 cycle for single-cycle ops, XLEN+1 cycles for MUL*/DIV*/REM*.
// Backpressure: result held while out_ready=0; in_ready=IDLE | (DONE & out_ready); flush wins.
module rv_alu_seq
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] w_sc_result;
  logic            w_accept;
  logic            w_is_mc;
  logic [SHW-1:0]  w_shamt;

  assign in_ready   = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_shamt    = in_b[SHW-1:0];
  assign out_valid  = (r_state == DONE);
  assign out_result = r_result;

  // Single-cycle datapath; unknown codes (and M-ops when no MDU) give 0.
  always_comb begin
    w_sc_result = '0;
    case (alu_op_e'(in_op))
      OP_ADD:   w_sc_result = in_a + in_b;
      OP_SUB:   w_sc_result = in_a - in_b;
      OP_AND:   w_sc_result = in_a & in_b;
      OP_OR:    w_sc_result = in_a | in_b;
      OP_XOR:   w_sc_result = in_a ^ in_b;
      OP_SLT:   w_sc_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU:  w_sc_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      OP_SLL:   w_sc_result = in_a << w_shamt;
      OP_SRL:   w_sc_result = in_a >> w_shamt;
      OP_SRA:   w_sc_result = $unsigned($signed(in_a) >>> w_shamt);
      OP_PASSB: w_sc_result = in_b;
      default:  w_sc_result = '0;
    endcase
  end

`ifdef RV_ALU_MDU_EN
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic              w_start;
  logic              w_iter_done;
  logic              w_fin;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_md_result;
  alu_op_e           r_op;
  logic              r_neg;
  logic              r_a_neg;
  logic              r_b_zero;
  logic [XLEN-1:0]   r_a;

  assign w_is_mc = is_multicycle(in_op);
  assign w_a_neg = op_a_signed(in_op) & in_a[XLEN-1];
  assign w_b_neg = op_b_signed(in_op) & in_b[XLEN-1];
  assign w_ma    = w_a_neg ? -in_a : in_a;
  assign w_mb    = w_b_neg ? -in_b : in_b;
  assign w_start = w_accept & w_is_mc;
  assign w_fin   = (r_state == BUSY) & w_iter_done;
  assign busy    = (r_state == BUSY);

  rv_alu_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_kill  (flush),
    .i_start (w_start),
    .i_div   (is_div_op(in_op)),
    .i_ma    (w_ma),
    .i_mb    (w_mb),
    .o_done  (w_iter_done),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // Remember what the final sign fixup needs, captured with the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_neg    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a      <= '0;
    end else if (w_start) begin
      r_op     <= alu_op_e'(in_op);
      r_neg    <= w_a_neg ^ w_b_neg;
      r_a_neg  <= w_a_neg;
      r_b_zero <= (in_b == '0);
      r_a      <= in_a;
    end
  end

  // Sign fixup and half selection on the last iterator step; divide-by-zero overrides.
  always_comb begin
    w_prod      = {w_hi, w_lo};
    w_prod_s    = r_neg ? -w_prod : w_prod;
    w_md_result = '0;
    case (r_op)
      OP_MUL:                       w_md_result = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_md_result = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_md_result = r_b_zero ? DIV_BY_ZERO_Q[XLEN-1:0] :
                                                  (r_neg ? -w_lo : w_lo);
      OP_REM, OP_REMU:              w_md_result = r_b_zero ? r_a :
                                                  (r_a_neg ? -w_hi : w_hi);
      default:                      w_md_result = '0;
    endcase
  end
`else
  assign w_is_mc = 1'b0;
  assign busy    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: accept from IDLE or from DONE as the result drains; flush overrides all.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_is_mc ? BUSY : DONE;
`ifdef RV_ALU_MDU_EN
      BUSY: if (w_fin) w_state_nxt = DONE;
`endif
      DONE: if (out_ready) w_state_nxt = w_accept ? (w_is_mc ? BUSY : DONE) : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // Result register: loaded on single-cycle accept or iterator completion, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_accept & ~w_is_mc) begin
      r_result <= w_sc_result;
`ifdef RV_ALU_MDU_EN
    end else if (w_fin & ~flush) begin
      r_result <= w_md_result;
`endif
    end
  end

endmodule
